// File: rtl/comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and flag-vector layout.
package comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int FLAG_GT = 2;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_LT = 0;

  function automatic logic [2:0] pack_flags(input logic gt, input logic eq, input logic lt);
    logic [2:0] f;
    f          = '0;
    f[FLAG_GT] = gt;
    f[FLAG_EQ] = eq;
    f[FLAG_LT] = lt;
    return f;
  endfunction

endpackage

// File: rtl/comparator_serial_n_bit_if.sv
// Request/status bundle between a requester and the serial comparator.
interface comparator_serial_n_bit_if #(
  parameter int WIDTH = 16
) ();
  logic             Enable_In;
  logic             Start_In;
  logic             Signed_In;
  logic [WIDTH-1:0] Data_A_In;
  logic [WIDTH-1:0] Data_B_In;
  logic             Busy_Out;
  logic             Valid_Out;

  modport master (
    output Enable_In, Start_In, Signed_In, Data_A_In, Data_B_In,
    input  Busy_Out, Valid_Out
  );

  modport slave (
    input  Enable_In, Start_In, Signed_In, Data_A_In, Data_B_In,
    output Busy_Out, Valid_Out
  );
endinterface

// File: rtl/comparator_chunk_cell.sv
// Combinational CHUNK-bit magnitude compare; invert_msb turns a signed chunk into offset binary.
module comparator_chunk_cell #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             invert_msb,
  output logic             gt,
  output logic             eq,
  output logic             lt
);
  logic [CHUNK-1:0] a_x;
  logic [CHUNK-1:0] b_x;

  always_comb begin
    a_x            = a;
    b_x            = b;
    a_x[CHUNK-1]   = a[CHUNK-1] ^ invert_msb;
    b_x[CHUNK-1]   = b[CHUNK-1] ^ invert_msb;
    gt             = (a_x > b_x);
    eq             = (a_x == b_x);
    lt             = (a_x < b_x);
  end
endmodule

// File: rtl/comparator_serial_n_bit.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle, unsigned or signed.
// Build option EARLY_EXIT_EN: stop on the first unequal chunk instead of walking all chunks.
module comparator_serial_n_bit
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                      Clock_In,
  input  logic                      Reset_In,
  comparator_serial_n_bit_if.slave  bus,
  // flags are tri-state nets, so they stay as plain ports
  output wire                       A_gt_B_Out,
  output wire                       A_eq_B_Out,
  output wire                       A_lt_B_Out
);
  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CHUNKS - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [2:0]       flags_q, flags_d;
`ifndef EARLY_EXIT_EN
  logic [1:0]       sticky_q, sticky_d;  // {gt, lt} of the first unequal chunk
`endif

  logic [CHUNK-1:0] a_ch [NUM_CHUNKS];
  logic [CHUNK-1:0] b_ch [NUM_CHUNKS];
  logic             c_gt, c_eq, c_lt;
  logic             start_ok;

  // chunk 0 is the most significant slice
  for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_ch
    assign a_ch[gi] = a_q[WIDTH-1-gi*CHUNK -: CHUNK];
    assign b_ch[gi] = b_q[WIDTH-1-gi*CHUNK -: CHUNK];
  end

  comparator_chunk_cell #(.CHUNK(CHUNK)) u_cell (
    .a          (a_ch[idx_q]),
    .b          (b_ch[idx_q]),
    .invert_msb (sgn_q && (idx_q == '0)),
    .gt         (c_gt),
    .eq         (c_eq),
    .lt         (c_lt)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    flags_d  = flags_q;
`ifndef EARLY_EXIT_EN
    sticky_d = sticky_q;
`endif
    start_ok = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.Start_In) start_ok = 1'b1;
        else              state_d  = ST_IDLE;
      end
      ST_COMPARE: begin
`ifdef EARLY_EXIT_EN
        if (!c_eq || idx_q == IDX_LAST) begin
          flags_d = pack_flags(c_gt, c_eq, c_lt);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
`else
        if (sticky_q == 2'b00 && !c_eq) sticky_d = {c_gt, c_lt};
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          if (sticky_q != 2'b00) flags_d = pack_flags(sticky_q[1], 1'b0, sticky_q[0]);
          else                   flags_d = pack_flags(c_gt, c_eq, c_lt);
        end else begin
          idx_d = idx_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_ok) begin
      state_d  = ST_COMPARE;
      idx_d    = '0;
      a_d      = bus.Data_A_In;
      b_d      = bus.Data_B_In;
      sgn_d    = bus.Signed_In;
`ifndef EARLY_EXIT_EN
      sticky_d = 2'b00;
`endif
    end
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      flags_q  <= '0;
`ifndef EARLY_EXIT_EN
      sticky_q <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      flags_q  <= flags_d;
`ifndef EARLY_EXIT_EN
      sticky_q <= sticky_d;
`endif
    end
  end

  assign bus.Busy_Out  = (state_q == ST_COMPARE);
  assign bus.Valid_Out = (state_q == ST_DONE);

  assign A_gt_B_Out = bus.Enable_In ? flags_q[FLAG_GT] : 1'bz;
  assign A_eq_B_Out = bus.Enable_In ? flags_q[FLAG_EQ] : 1'bz;
  assign A_lt_B_Out = bus.Enable_In ? flags_q[FLAG_LT] : 1'bz;

endmodule
